// File: rtl/gfx_rom_responder.sv
// Graphics ROM responder: per-port one-entry last-address cache in front of a
// single round-robin arbitrated SDRAM read port.
module gfx_rom_responder #(
  parameter int PORTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic                CLK96,
  input  logic                RESET96,
  input  logic [PORTS-1:0]    REQ_CS,
  input  logic [PORTS*AW-1:0] REQ_ADDR,
  output logic [PORTS-1:0]    REQ_OK,
  output logic [PORTS*DW-1:0] REQ_DOUT,
  input  logic                INVALIDATE,
  output logic                MEM_RD,
  output logic [AW-1:0]       MEM_ADDR,
  input  logic                MEM_ACK,
  input  logic                MEM_DST,
  input  logic [DW-1:0]       MEM_DATA
);

  // state    | meaning
  // ST_IDLE  | no request outstanding; arbitrate misses
  // ST_ISSUE | MEM_RD held until MEM_ACK
  // ST_WAIT  | accepted, waiting for MEM_DST
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [1:0]       state;
  logic [GW-1:0]    gnt;
  logic [GW-1:0]    rr;
  logic [AW-1:0]    addr_q;
  logic             stale;
  logic [AW-1:0]    cache_addr [PORTS];
  logic [PORTS-1:0] valid;

  logic [PORTS-1:0] hit;
  logic [PORTS-1:0] miss;
  logic             any_miss;
  logic [GW-1:0]    pick;
  logic             complete;
  logic             commit;
  logic [PORTS-1:0] valid_nx;
  logic [AW-1:0]    cache_addr_nx [PORTS];
  logic [PORTS-1:0] ok_nx;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      hit[i]  = REQ_CS[i] & valid[i] & (REQ_ADDR[i*AW +: AW] == cache_addr[i]);
      miss[i] = REQ_CS[i] & ~hit[i] & (state == ST_IDLE);
    end
  end

  // First missing port after the last grant, wrapping modulo PORTS
  always_comb begin
    int idx;
    any_miss = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = (int'(rr) + k) % PORTS;
      if (!any_miss && miss[idx]) begin
        any_miss = 1'b1;
        pick     = GW'(idx);
      end
    end
  end

  assign complete = ((state == ST_ISSUE) && MEM_ACK && MEM_DST) ||
                    ((state == ST_WAIT) && MEM_DST);
  assign commit   = complete & ~stale & ~INVALIDATE;

  // OK is the hit test against the cache contents as they stand after this edge
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      valid_nx[i]      = valid[i];
      cache_addr_nx[i] = cache_addr[i];
      if (commit && (gnt == GW'(i))) begin
        valid_nx[i]      = 1'b1;
        cache_addr_nx[i] = addr_q;
      end
      if (INVALIDATE) valid_nx[i] = 1'b0;
      ok_nx[i] = REQ_CS[i] & valid_nx[i] & (REQ_ADDR[i*AW +: AW] == cache_addr_nx[i]);
    end
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      rr       <= GW'(PORTS - 1);
      addr_q   <= '0;
      stale    <= 1'b0;
      valid    <= '0;
      REQ_OK   <= '0;
      REQ_DOUT <= '0;
      MEM_RD   <= 1'b0;
      MEM_ADDR <= '0;
      for (int i = 0; i < PORTS; i++) cache_addr[i] <= '0;
    end else begin
      REQ_OK <= ok_nx;
      valid  <= valid_nx;
      for (int i = 0; i < PORTS; i++) cache_addr[i] <= cache_addr_nx[i];
      if (commit) REQ_DOUT[int'(gnt)*DW +: DW] <= MEM_DATA;
      if (INVALIDATE && (state != ST_IDLE)) stale <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (any_miss) begin
            gnt      <= pick;
            addr_q   <= REQ_ADDR[int'(pick)*AW +: AW];
            MEM_ADDR <= REQ_ADDR[int'(pick)*AW +: AW];
            MEM_RD   <= 1'b1;
            rr       <= pick;
            stale    <= 1'b0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (MEM_ACK) begin
            MEM_RD <= 1'b0;
            state  <= MEM_DST ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (MEM_DST) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gfx_rom_responder.md
Name: gfx_rom_responder

Overview:
- Memory-side responder for the graphics ROM CS/ADDR/OK/DOUT request interface used by the tile and sprite fetch engines.
- Serves PORTS independent requesters and round-robin arbitrates misses onto a single SDRAM read port.
- Keeps a one-entry last-address cache per port, so a repeated fetch returns OK without a memory access.
- Sits between the gfx address/decode logic and the SDRAM controller.

Parameters:
PORTS, 4, number of requester ports
AW, 22, word address width
DW, 32, data width

Ports:
CLK96  in  1  system clock; all logic on rising edge
RESET96  in  1  synchronous active-high reset
REQ_CS  in  PORTS  per-port request strobe; held high until OK is seen
REQ_ADDR  in  PORTS*AW  per-port word address; port i occupies bits [i*AW +: AW]
REQ_OK  out  PORTS  per-port data-valid for the current REQ_ADDR
REQ_DOUT  out  PORTS*DW  per-port returned data; port i occupies bits [i*DW +: DW]
INVALIDATE  in  1  one-cycle pulse; flush all caches (object bank rewrite)
MEM_RD  out  1  SDRAM read request
MEM_ADDR  out  AW  SDRAM word address
MEM_ACK  in  1  SDRAM accepted request
MEM_DST  in  1  MEM_DATA valid this cycle
MEM_DATA  in  DW  SDRAM read data

Behaviour:
- Reset (synchronous, RESET96 high at edge) forces all of the following, including mid-transaction; any in-flight SDRAM reply after reset is ignored:
  - REQ_OK=0, REQ_DOUT=0, MEM_RD=0, MEM_ADDR=0
  - all cache valid bits=0, state=IDLE
  - rr pointer=PORTS-1, so port 0 has first priority
- Per-port cache state: cache_addr[i] (AW bits), valid[i], REQ_DOUT[i] (holds the cached data).
- Hit[i] = REQ_CS[i] & valid[i] & (REQ_ADDR[i]==cache_addr[i]).
- Miss[i] = REQ_CS[i] & !hit[i] & not currently granted.
- REQ_OK[i] is registered:
  - next value = hit[i] evaluated after any cache update on that edge.
  - A hit gives OK one cycle after CS/ADDR is presented.
  - OK falls the edge after CS drops or ADDR changes.
- FSM states:
  - IDLE: if any miss, grant the first missing port searching from rr+1 modulo PORTS. Latch gnt and addr; MEM_ADDR<=addr; MEM_RD<=1; rr<=gnt; stale<=0; go to ISSUE.
  - ISSUE: hold MEM_RD and MEM_ADDR until MEM_ACK is sampled high, then MEM_RD<=0. If MEM_DST is also high that cycle, complete immediately; else go to WAIT.
  - WAIT: on MEM_DST, complete. Completion when stale=0: cache_addr[gnt]<=addr, REQ_DOUT[gnt]<=MEM_DATA, valid[gnt]<=1, REQ_OK[gnt]<=REQ_CS[gnt]&(REQ_ADDR[gnt]==addr). Completion when stale=1: data discarded. Either way, state returns to IDLE.
- Nominal miss latency, with CS high at cycle 0:
  - MEM_RD high after edge 1.
  - ACK at edge 2, DST at edge 3.
  - REQ_OK high after edge 3.
- Requester changes ADDR or drops CS while its request is in flight: the request still completes and the cache is written, but OK is not asserted for the new address. The new address is a fresh miss, arbitrated later.
- INVALIDATE:
  - clears all valid bits and all REQ_OK on the next edge
  - sets stale=1 if state is ISSUE or WAIT
  - a completion in the same cycle as INVALIDATE is treated as stale
- Simultaneous hit on one port and completion on another: both handled in the same cycle, with no stall.
- No back-to-back overlap: at most one SDRAM request outstanding.
- Out-of-range ADDR does not exist; all AW bits are passed through unchanged.

Test Plan:
- Reset: hold RESET96 for 2 cycles while MEM_DST=1 -> REQ_OK=0000, MEM_RD=0, REQ_DOUT all 0.
- Single miss: port1 CS=1, ADDR=0x12345, ACK at cycle 2, DST with data 0xDEADBEEF at cycle 3 -> MEM_ADDR=0x12345, REQ_OK[1]=1 after edge 3, port-1 REQ_DOUT=0xDEADBEEF. Then drop CS -> OK falls the next edge.
- Hit: re-raise port1 CS with ADDR=0x12345 -> OK=1 after 1 edge, MEM_RD stays 0.
- Round-robin: ports 0, 2 and 3 miss simultaneously with rr=2 after reset activity -> grant order 3, 0, 2, with MEM_ADDR matching each port's ADDR.
- Address change in flight: port0 changes ADDR 0x10 -> 0x20 before DST -> OK not asserted for 0x10 data; a second MEM_RD is issued with MEM_ADDR=0x20, then OK=1.
- Invalidate: INVALIDATE pulse in WAIT for port2 addr 0x40, then CS held -> completion discarded, valid cleared, re-issue of 0x40, then OK=1. Prior hits on other ports become misses.
